// File: rtl/letc_core_pkg.sv
// letc_core_pkg: core-level AXI response codes and fixed single-beat attributes
package letc_core_pkg;
    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
endpackage

// File: rtl/letc_pkg.sv
// letc_pkg: LETC-wide types shared by every core block
package letc_pkg;
    localparam int PADDR_WIDTH = 32;
    typedef logic [PADDR_WIDTH-1:0] paddr_t;
    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALFWORD = 2'b01,
        SIZE_WORD     = 2'b10
    } size_e;
endpackage

// File: rtl/letc_core_limp_if.sv
// letc_core_limp_if: LIMP request/response link between caches and the bus bridge
interface letc_core_limp_if;
    import letc_pkg::*;
    logic        valid;
    logic        ready;
    logic        wen_nren;
    logic        bypass;
    size_e       size;
    paddr_t      addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport requestor (output valid, wen_nren, bypass, size, addr, wdata, input ready, rdata);
    modport servicer  (input valid, wen_nren, bypass, size, addr, wdata, output ready, rdata);
endinterface

// File: rtl/letc_core_axi_lane_align.sv
// letc_core_axi_lane_align: byte-lane strobes/replication for stores and lane extraction for loads
module letc_core_axi_lane_align
    import letc_pkg::*;
(
    input  size_e       i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Stores replicate the datum into every lane; loads shift the addressed lane down and zero-extend
    always_comb begin
        byte_lane = 8'(i_rdata >> {i_addr_lo, 3'b000});
        half_lane = 16'(i_rdata >> {i_addr_lo[1], 4'b0000});
        o_wstrb   = (i_size == SIZE_BYTE)     ? 4'b0001 << i_addr_lo :
                    (i_size == SIZE_HALFWORD) ? (i_addr_lo[1] ? 4'b1100 : 4'b0011) : 4'hF;
        o_wdata   = (i_size == SIZE_BYTE)     ? {4{i_wdata[7:0]}} :
                    (i_size == SIZE_HALFWORD) ? {2{i_wdata[15:0]}} : i_wdata;
        o_rdata   = (i_size == SIZE_BYTE)     ? {24'h0, byte_lane} :
                    (i_size == SIZE_HALFWORD) ? {16'h0, half_lane} : i_rdata;
    end
endmodule

// File: rtl/letc_core_axi_fsm.sv
// letc_core_axi_fsm: LIMP-to-AXI4 bridge issuing one single-beat transaction at a time
module letc_core_axi_fsm
    import letc_pkg::*;
    import letc_core_pkg::*;
#(
    parameter int                      AXI_ADDR_WIDTH = PADDR_WIDTH,
    parameter int                      AXI_ID_WIDTH   = 4,
    parameter logic [AXI_ID_WIDTH-1:0] AXI_ID         = '0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    letc_core_limp_if.servicer        limp,
    output logic                      o_bus_error,
    output logic                      o_awvalid,
    input  logic                      i_awready,
    output logic [AXI_ADDR_WIDTH-1:0] o_awaddr,
    output logic [AXI_ID_WIDTH-1:0]   o_awid,
    output logic [7:0]                o_awlen,
    output logic [2:0]                o_awsize,
    output logic [1:0]                o_awburst,
    output logic                      o_wvalid,
    input  logic                      i_wready,
    output logic [31:0]               o_wdata,
    output logic [3:0]                o_wstrb,
    output logic                      o_wlast,
    input  logic                      i_bvalid,
    output logic                      o_bready,
    input  logic [1:0]                i_bresp,
    output logic                      o_arvalid,
    input  logic                      i_arready,
    output logic [AXI_ADDR_WIDTH-1:0] o_araddr,
    output logic [AXI_ID_WIDTH-1:0]   o_arid,
    output logic [7:0]                o_arlen,
    output logic [2:0]                o_arsize,
    output logic [1:0]                o_arburst,
    input  logic                      i_rvalid,
    output logic                      o_rready,
    input  logic [31:0]               i_rdata,
    input  logic [1:0]                i_rresp,
    input  logic                      i_rlast
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, DONE} state_e;

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    size_e                     size_q, size_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      arvalid_q, arvalid_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic [31:0]               rdata_aligned;
    logic                      unused_inputs;

    letc_core_axi_lane_align u_align (
        .i_size    (size_q),
        .i_addr_lo (addr_q[1:0]),
        .i_wdata   (wdata_q),
        .i_rdata   (i_rdata),
        .o_wstrb   (o_wstrb),
        .o_wdata   (o_wdata),
        .o_rdata   (rdata_aligned)
    );

    // Next state plus capture of the request on acceptance and of the response on completion
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        unique case (state_q)
            IDLE: if (limp.valid) begin
                addr_d    = AXI_ADDR_WIDTH'(limp.addr);
                size_d    = limp.size;
                wdata_d   = limp.wdata;
                arvalid_d = !limp.wen_nren;
                awvalid_d = limp.wen_nren;
                wvalid_d  = limp.wen_nren;
                state_d   = limp.wen_nren ? WR_ADDR_DATA : RD_ADDR;
            end
            RD_ADDR: if (i_arready) begin
                arvalid_d = 1'b0;
                state_d   = RD_DATA;
            end
            RD_DATA: if (i_rvalid) begin
                rdata_d = rdata_aligned;
                err_d   = axi_resp_e'(i_rresp) != AXI_RESP_OKAY;
                state_d = DONE;
            end
            WR_ADDR_DATA: begin
                awvalid_d = awvalid_q && !i_awready;
                wvalid_d  = wvalid_q && !i_wready;
                state_d   = (!awvalid_d && !wvalid_d) ? WR_RESP : WR_ADDR_DATA;
            end
            WR_RESP: if (i_bvalid) begin
                err_d   = axi_resp_e'(i_bresp) != AXI_RESP_OKAY;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers; reset abandons any transaction in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= SIZE_BYTE;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
        end
    end

    assign o_arvalid   = arvalid_q;
    assign o_awvalid   = awvalid_q;
    assign o_wvalid    = wvalid_q;
    assign o_rready    = state_q == RD_DATA;
    assign o_bready    = state_q == WR_RESP;
    assign limp.ready  = state_q == DONE;
    assign limp.rdata  = rdata_q;
    assign o_bus_error = (state_q == DONE) && err_q;
    assign o_awaddr    = {addr_q[AXI_ADDR_WIDTH-1:2], 2'b00};
    assign o_araddr    = {addr_q[AXI_ADDR_WIDTH-1:2], 2'b00};
    assign o_awid      = AXI_ID;
    assign o_arid      = AXI_ID;
    assign o_awlen     = AXI_LEN_SINGLE;
    assign o_arlen     = AXI_LEN_SINGLE;
    assign o_awsize    = AXI_SIZE_WORD;
    assign o_arsize    = AXI_SIZE_WORD;
    assign o_awburst   = AXI_BURST_INCR;
    assign o_arburst   = AXI_BURST_INCR;
    assign o_wlast     = 1'b1;
    assign unused_inputs = ^{i_rlast, limp.bypass};

    // Halfword and word requests must arrive naturally aligned
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (state_q == IDLE && limp.valid) |->
        !((limp.size == SIZE_HALFWORD && limp.addr[0]) || (limp.size == SIZE_WORD && limp.addr[1:0] != 2'b00)));
endmodule
